if_id_skid_reg: RTL
===================

Name: if_id_skid_reg

Overview:
- Pipeline boundary between the fetch stage and the decode stage.
- Captures the fetch bundle {pc, instruction, pc_plus4} each cycle using a valid/ready handshake.
- Holds up to two bundles (main + skid) so a decode stall never drops an instruction already fetched.
- Drives the fetch stage's PC write-enable, and kills in-flight bundles on a branch/jump flush.

Parameters:
- XLEN, 32, width of pc, pc_plus4 and instruction.
- NOP_INST, 32'h0000_0013, instruction word presented when output is invalid (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch bundle valid this cycle.
- in_pc  input  XLEN  PC of fetched instruction.
- in_instruction  input  XLEN  fetched instruction word.
- in_pc_plus4  input  XLEN  in_pc + 4 from fetch.
- in_ready  output  1  block can accept a bundle this cycle.
- pc_we  output  1  fetch PC advance enable; equals in_ready.
- flush  input  1  kill all held bundles and any bundle presented this cycle.
- out_valid  output  1  bundle at decode is valid.
- out_pc  output  XLEN  PC to decode.
- out_instruction  output  XLEN  instruction to decode; NOP_INST when out_valid=0.
- out_pc_plus4  output  XLEN  pc_plus4 to decode.
- out_ready  input  1  decode consumes the bundle this cycle.
- occupancy  output  2  number of held bundles (0..2); debug/verification.

Behaviour:
- Reset (rst=1 at edge): state EMPTY, occupancy=0, out_valid=0, out_pc=0, out_pc_plus4=0, out_instruction=NOP_INST, in_ready=1, pc_we=1. Reset dominates flush and all handshakes.
- Transfers: in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready.
- Latency: a bundle accepted at edge N is on out_* after edge N (one cycle) when the block was EMPTY or draining.
- Storage: main register drives out_*. Skid register only fills when main is held and a new bundle arrives.
- Output ordering: strict FIFO; the skid contents move to main on the out-transfer.
- States and transitions (flush=0):
  - EMPTY: in-transfer -> ONE (load main); otherwise stay in EMPTY.
  - ONE:
    - in-transfer & out-transfer -> ONE (main reloaded from input).
    - in-transfer only -> TWO (load skid).
    - out-transfer only -> EMPTY.
    - neither -> stay in ONE.
  - TWO: in_ready=0. out-transfer -> ONE (skid to main); otherwise hold.
- in_ready = (state != TWO). Combinational from state only; no dependence on out_ready, so there is no ready-path loop.
- out_valid = (state != EMPTY). out_* change only at clock edges.
- Flush:
  - Next state is EMPTY, and both registers are invalidated.
  - An input bundle presented the same cycle is discarded even if in_ready=1.
  - An out-transfer in the same cycle still counts as consumed by decode; the consumed bundle was already in decode.
- When out_valid=0, out_instruction=NOP_INST. out_pc and out_pc_plus4 hold their last value.
- No arithmetic: pc_plus4 passes through unchanged. Full XLEN widths everywhere, no truncation.
- in_valid=0 with in_ready=1: no state change except via out-transfer.
- Never silently drops a bundle or duplicates one. Every accepted, unflushed bundle appears exactly once at out_*.

Decomposition:
- core_pkg gains:
  - typedef if_id_data_t, if not already present: packed struct {pc, instruction, pc_plus4}.
  - localparam NOP_INST.
  - enum ifid_state_e {EMPTY, ONE, TWO}.
- Internally, main and skid are two instances of one sub-module, if_id_data_reg: a clocked if_id_data_t register with load enable and synchronous clear.
- The FSM and muxing stay in the top module.

Test Plan:
- Reset/idle: assert rst 2 cycles, in_valid=0 -> out_valid=0, out_instruction=32'h13, in_ready=1, pc_we=1, occupancy=0.
- Streaming: out_ready=1, present pc=0x00,0x04,0x08 with in_valid=1 on consecutive cycles -> out_pc 0x00,0x04,0x08 one cycle later each; in_ready stays 1.
- Stall absorb:
  - Stimulus: hold out_ready=0 after 0x00 is accepted, then present 0x04.
  - Required: occupancy=2, in_ready=0, pc_we=0, and 0x08 is not accepted.
  - Then raise out_ready: outputs 0x00, 0x04, 0x08 in order, with no loss.
- Flush with full buffer:
  - Stimulus: occupancy=2 (0x10, 0x14), then flush=1 with in_valid=1 and pc=0x18.
  - Required: next cycle out_valid=0, occupancy=0, out_instruction=32'h13.
  - Then 0x40 presented -> out_pc=0x40 next cycle.
- Simultaneous in/out in ONE: main=0x20, in_valid=1 pc=0x24, out_ready=1 -> after edge out_pc=0x24, occupancy=1.
- Mid-operation reset: occupancy=2, assert rst with flush=0 and in_valid=1 -> next cycle all outputs at reset values; the input bundle is not captured.

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch/decode types: the IF/ID bundle, the bubble instruction and
// the IF/ID buffer state encoding.
package core_pkg;

  localparam int          CORE_XLEN = 32;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_XLEN-1:0] instruction;
    logic [CORE_XLEN-1:0] pc_plus4;
  } if_id_data_t;

  // Encoding doubles as the held-bundle count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ifid_state_e;

endpackage

// File: rtl/if_id_data_reg.sv
// One IF/ID bundle register: load enable plus synchronous clear on reset.
module if_id_data_reg
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  if_id_data_t d,
  output if_id_data_t q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// Fetch->decode boundary: two-entry skid buffer (main + skid) with a
// registered, state-only in_ready and branch/jump flush.
module if_id_skid_reg
  import core_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instruction,
  input  logic [XLEN-1:0] in_pc_plus4,
  output logic            in_ready,
  output logic            pc_we,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instruction,
  output logic [XLEN-1:0] out_pc_plus4,
  input  logic            out_ready,
  output logic [1:0]      occupancy
);

  ifid_state_e state_q, state_d;
  if_id_data_t main_q, main_d, skid_q, in_data;
  logic        ld_main, ld_skid;
  logic        in_xfer, out_xfer;

  assign in_data = '{pc: in_pc, instruction: in_instruction, pc_plus4: in_pc_plus4};

  assign in_ready  = (state_q != TWO);
  assign pc_we     = in_ready;
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;

  // A flushed input never counts as accepted; out-transfer is unaffected.
  assign in_xfer  = in_valid & in_ready & ~flush;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    main_d  = in_data;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (in_xfer) begin
          state_d = ONE;
          ld_main = 1'b1;
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            ld_main = 1'b1;
          end else if (in_xfer) begin
            state_d = TWO;
            ld_skid = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: if (out_xfer) begin
          state_d = ONE;
          ld_main = 1'b1;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  if_id_data_reg u_main (
    .clk (clk),
    .rst (rst),
    .ld  (ld_main),
    .d   (main_d),
    .q   (main_q)
  );

  if_id_data_reg u_skid (
    .clk (clk),
    .rst (rst),
    .ld  (ld_skid),
    .d   (in_data),
    .q   (skid_q)
  );

  // pc fields keep their last value while invalid; only the instruction bubbles.
  assign out_pc          = main_q.pc;
  assign out_pc_plus4    = main_q.pc_plus4;
  assign out_instruction = out_valid ? main_q.instruction : NOP_INST;

endmodule
